// File: rtl/seven_seg_reader_pkg.sv
// Shared segment constants and FSM state type for the 7-segment reader and decoder benches.
// Segment bit order is {g,f,e,d,c,b,a}; 1 = segment lit.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;

  typedef enum logic {
    S_TRACK,
    S_EMIT
  } state_t;

endpackage

// File: rtl/seven_seg_reader_if.sv
// Report handshake between the 7-segment reader (master) and its consumer (slave).
interface seven_seg_reader_if;
  logic       bin_valid;
  logic       bin_ready;
  logic [3:0] bin_out;
  logic       err;

  modport master (output bin_valid, bin_out, err, input bin_ready);
  modport slave  (input bin_valid, bin_out, err, output bin_ready);
endinterface

// File: rtl/seg_pattern_lut.sv
// Combinational 7-segment pattern -> {err, bin} recogniser.
// Define SEG_HEX_EN to accept the A..F hex glyphs as legal digits.
module seg_pattern_lut
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       err,
  output logic [3:0] bin
);

  always_comb begin
    err = 1'b0;
    bin = 4'h0;
    case (seg)
      SEG_0: bin = 4'h0;
      SEG_1: bin = 4'h1;
      SEG_2: bin = 4'h2;
      SEG_3: bin = 4'h3;
      SEG_4: bin = 4'h4;
      SEG_5: bin = 4'h5;
      SEG_6: bin = 4'h6;
      SEG_7: bin = 4'h7;
      SEG_8: bin = 4'h8;
      SEG_9: bin = 4'h9;
`ifdef SEG_HEX_EN
      SEG_A: bin = 4'hA;
      SEG_B: bin = 4'hB;
      SEG_C: bin = 4'hC;
      SEG_D: bin = 4'hD;
      SEG_E: bin = 4'hE;
      SEG_F: bin = 4'hF;
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Samples a 7-segment bus, debounces it and reports each new stable digit once over valid/ready.
// Hex glyph acceptance is controlled by SEG_HEX_EN (see seg_pattern_lut).
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                seg_in,
  seven_seg_reader_if.master        bin
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  logic [6:0]    sync1;
  logic [6:0]    seg_s;
  logic [6:0]    candidate;
  logic [6:0]    last_reported;
  logic [CW-1:0] cnt;
  state_t        state;
  logic          valid_q;
  logic [3:0]    bin_q;
  logic          err_q;
  logic          lut_err;
  logic [3:0]    lut_bin;

  seg_pattern_lut u_lut (
    .seg (candidate),
    .err (lut_err),
    .bin (lut_bin)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1         <= '0;
      seg_s         <= '0;
      candidate     <= SEG_BLANK;
      cnt           <= '0;
      last_reported <= SEG_BLANK;
      state         <= S_TRACK;
      valid_q       <= 1'b0;
      bin_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      sync1 <= seg_in;
      seg_s <= sync1;
      case (state)
        S_TRACK: begin
          if (seg_s != candidate) begin
            candidate <= seg_s;
            cnt       <= CW'(1);
          end else if (cnt < CW'(STABLE_CYCLES)) begin
            cnt <= cnt + CW'(1);
            // Decide on the edge where cnt reaches STABLE_CYCLES, so the report
            // register loads in the same edge rather than one later.
            if (cnt == CW'(STABLE_CYCLES - 1)) begin
              if (candidate == SEG_BLANK) begin
                last_reported <= SEG_BLANK;
              end else if (candidate != last_reported) begin
                bin_q         <= lut_bin;
                err_q         <= lut_err;
                last_reported <= candidate;
                valid_q       <= 1'b1;
                state         <= S_EMIT;
              end
            end
          end
        end
        S_EMIT: begin
          if (bin.bin_ready) begin
            valid_q <= 1'b0;
            state   <= S_TRACK;
          end
        end
        default: state <= S_TRACK;
      endcase
    end
  end

  assign bin.bin_valid = valid_q;
  assign bin.bin_out   = bin_q;
  assign bin.err       = err_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Scoreboard bench for seven_seg_reader: expected reports are queued on stimulus, popped on handshake.
module tb_seven_seg_reader;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;

  seven_seg_reader_if bus ();

  seven_seg_reader #(.STABLE_CYCLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seg_in (seg_in),
    .bin    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp     = 0;
  int unsigned n_err     = 0;
  int unsigned n_reports = 0;
  int unsigned n_pushed  = 0;
  logic [7:0]  sb[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected report {3'b0, err, bin} for a non-blank pattern
  function automatic logic [7:0] ref_report(input logic [6:0] p);
    case (p)
      7'h3F: return 8'h00;
      7'h06: return 8'h01;
      7'h5B: return 8'h02;
      7'h4F: return 8'h03;
      7'h66: return 8'h04;
      7'h6D: return 8'h05;
      7'h7D: return 8'h06;
      7'h07: return 8'h07;
      7'h7F: return 8'h08;
      7'h6F: return 8'h09;
`ifdef SEG_HEX_EN
      7'h77: return 8'h0A;
      7'h7C: return 8'h0B;
      7'h39: return 8'h0C;
      7'h5E: return 8'h0D;
      7'h79: return 8'h0E;
      7'h71: return 8'h0F;
`endif
      default: return 8'h10;
    endcase
  endfunction

  task automatic expect_report(input logic [6:0] p);
    sb.push_back(ref_report(p));
    n_pushed++;
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Handshake happens on the next rising edge when both are high at the falling edge
  always @(negedge clk) begin
    if (rst_n && bus.bin_valid && bus.bin_ready) begin
      n_reports++;
      if (sb.size() == 0) check("spurious_report", 8'(sb.size()), 8'd1);
      else check("report", {3'b000, bus.err, bus.bin_out}, sb.pop_front());
    end
  end

  initial begin
    int unsigned lat;
    int unsigned base;

    rst_n         = 1'b0;
    seg_in        = 7'h7F;
    bus.bin_ready = 1'b1;

    // Reset with a digit already on the bus
    for (int unsigned i = 0; i < 3; i++) begin
      tick(1);
      check("rst_valid", {7'b0, bus.bin_valid}, 8'h00);
      check("rst_out",   {4'b0, bus.bin_out},   8'h00);
      check("rst_err",   {7'b0, bus.err},       8'h00);
    end
    expect_report(7'h7F);
    rst_n = 1'b1;
    tick(20);
    check("t1_count", 8'(n_reports), 8'd1);

    // Basic report with latency
    base = n_reports;
    expect_report(7'h4F);
    seg_in = 7'h4F;
    lat = 0;
    for (int unsigned n = 1; n <= 20; n++) begin
      tick(1);
      if (bus.bin_valid) begin
        lat = n;
        break;
      end
    end
    check("latency", 8'(lat), 8'd6);
    tick(1);
    check("valid_one_clk", {7'b0, bus.bin_valid}, 8'h00);
    tick(50);
    check("t2_count", 8'(n_reports - base), 8'd1);

    // Short glitch of 1 followed by 2
    base = n_reports;
    seg_in = 7'h06;
    tick(2);
    expect_report(7'h5B);
    seg_in = 7'h5B;
    tick(20);
    check("t3_count", 8'(n_reports - base), 8'd1);

    // Backpressure
    base = n_reports;
    bus.bin_ready = 1'b0;
    expect_report(7'h6D);
    seg_in = 7'h6D;
    tick(10);
    for (int unsigned i = 0; i < 10; i++) begin
      tick(1);
      check("bp_valid", {7'b0, bus.bin_valid}, 8'h01);
      check("bp_out",   {3'b0, bus.err, bus.bin_out}, 8'h05);
    end
    bus.bin_ready = 1'b1;
    tick(1);
    check("bp_release", {7'b0, bus.bin_valid}, 8'h00);
    tick(10);
    check("t4_count", 8'(n_reports - base), 8'd1);

    // Hex glyph and an illegal pattern
    base = n_reports;
    expect_report(7'h77);
    seg_in = 7'h77;
    tick(12);
    expect_report(7'h49);
    seg_in = 7'h49;
    tick(12);
    check("t5_count", 8'(n_reports - base), 8'd2);

    // Blank between identical digits re-arms reporting
    base = n_reports;
    expect_report(7'h7F);
    seg_in = 7'h7F;
    tick(8);
    seg_in = 7'h00;
    tick(8);
    expect_report(7'h7F);
    seg_in = 7'h7F;
    tick(12);
    check("t6_count", 8'(n_reports - base), 8'd2);

    // Reset while a report is pending drops it; the held digit reports again afterwards
    base = n_reports;
    bus.bin_ready = 1'b0;
    seg_in = 7'h3F;
    lat = 0;
    for (int unsigned n = 1; n <= 20; n++) begin
      tick(1);
      if (bus.bin_valid) begin
        lat = n;
        break;
      end
    end
    check("abort_pending", {7'b0, bus.bin_valid}, 8'h01);
    rst_n = 1'b0;
    tick(1);
    check("abort_valid", {7'b0, bus.bin_valid}, 8'h00);
    tick(2);
    expect_report(7'h3F);
    rst_n = 1'b1;
    bus.bin_ready = 1'b1;
    tick(20);
    check("t6b_count", 8'(n_reports - base), 8'd1);

    check("sb_drained", 8'(sb.size()), 8'd0);
    check("report_total", 8'(n_reports), 8'(n_pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
